// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a DEPTH-entry skid FIFO that absorbs fetch beats while ID stalls.
// Optional performance counters (bubble_cnt, stall_cnt) are enabled by defining IF_ID_PERF_EN.
module if_id_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h00000013)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_ID,
    input  logic                       flush,
    input  logic                       fetch_valid,
    input  logic [XLEN-1:0]            fetch_pc,
    input  logic [XLEN-1:0]            fetch_inst,
    output logic                       fetch_ready,
    output logic [XLEN-1:0]            pc_ID,
    output logic [XLEN-1:0]            inst_ID,
    output logic                       valid_ID,
`ifdef IF_ID_PERF_EN
    output logic [31:0]                bubble_cnt,
    output logic [31:0]                stall_cnt,
`endif
    output logic [$clog2(DEPTH):0]     buf_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] pc_q, pc_d, inst_q, inst_d;
    logic            valid_q, valid_d;
    logic            accept, wr_en;

    // Ready depends only on registered count, never on stall_ID, so no comb path upstream.
    assign fetch_ready = !rst && (count_q < FullCnt);
    assign accept      = fetch_valid && fetch_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        wr_en    = 1'b0;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
            inst_d   = NOP_INST;
        end else if (stall_ID) begin
            if (accept) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
                count_d  = count_q + CW'(1);
            end
        end else if (count_q != '0) begin
            pc_d     = pc_mem[rd_ptr_q];
            inst_d   = inst_mem[rd_ptr_q];
            valid_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (accept) begin
                // Pop and push in the same cycle: occupancy unchanged.
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                count_d = count_q - CW'(1);
            end
        end else if (accept) begin
            pc_d    = fetch_pc;
            inst_d  = fetch_inst;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= '0;
            inst_q   <= NOP_INST;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr_q]   <= fetch_pc;
            inst_mem[wr_ptr_q] <= fetch_inst;
        end
    end

    assign pc_ID     = pc_q;
    assign inst_ID   = inst_q;
    assign valid_ID  = valid_q;
    assign buf_count = count_q;

`ifdef IF_ID_PERF_EN
    logic [31:0] bubble_cnt_q, stall_cnt_q;
    logic        bubble_evt, stall_evt;

    assign bubble_evt = !flush && !stall_ID && (count_q == '0) && !accept;
    assign stall_evt  = !flush && stall_ID;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (bubble_evt && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (stall_evt && (stall_cnt_q != '1))   stall_cnt_q  <= stall_cnt_q + 32'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`else
    // Counters absent in this build.
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a queue scoreboard holds accepted beats and is popped when ID loads.
module tb_if_id_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, stall_ID, flush, fetch_valid;
    logic [31:0] fetch_pc, fetch_inst;
    logic        fetch_ready, valid_ID;
    logic [31:0] pc_ID, inst_ID;
    logic [1:0]  buf_count;
`ifdef IF_ID_PERF_EN
    logic [31:0] bubble_cnt, stall_cnt;
`endif

    if_id_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_ID    (stall_ID),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_inst  (fetch_inst),
        .fetch_ready (fetch_ready),
        .pc_ID       (pc_ID),
        .inst_ID     (inst_ID),
        .valid_ID    (valid_ID),
`ifdef IF_ID_PERF_EN
        .bubble_cnt  (bubble_cnt),
        .stall_cnt   (stall_cnt),
`endif
        .buf_count   (buf_count)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_pc, exp_inst;
    logic        exp_valid;
    int unsigned m_bub, m_stall;

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]} ^ 32'h00A50000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check pre-edge ready/occupancy, advance the model, check registered outputs.
    task automatic step(input logic s, input logic f, input logic fv, input logic [31:0] pc,
                        output logic acc);
        logic        exp_ready;
        logic [63:0] head;
        stall_ID    = s;
        flush       = f;
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_inst  = mk_inst(pc);
        #1;
        exp_ready = !rst && (sb.size() < DEPTH);
        check("fetch_ready", {31'd0, fetch_ready}, {31'd0, exp_ready});
        if (!rst) check("buf_count_pre", {30'd0, buf_count}, 32'(sb.size()));
        acc = fv && exp_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            exp_valid = 1'b0; exp_inst = NOP; exp_pc = '0;
            m_bub = 0; m_stall = 0;
        end else if (f) begin
            sb.delete();
            exp_valid = 1'b0; exp_inst = NOP;
        end else if (s) begin
            if (acc) sb.push_back({pc, mk_inst(pc)});
            m_stall++;
        end else begin
            if (acc) sb.push_back({pc, mk_inst(pc)});
            if (sb.size() > 0) begin
                head = sb.pop_front();
                exp_valid = 1'b1; exp_pc = head[63:32]; exp_inst = head[31:0];
            end else begin
                exp_valid = 1'b0; exp_inst = NOP;
                m_bub++;
            end
        end
        check("valid_ID", {31'd0, valid_ID}, {31'd0, exp_valid});
        check("pc_ID", pc_ID, exp_pc);
        check("inst_ID", inst_ID, exp_inst);
        check("buf_count", {30'd0, buf_count}, 32'(sb.size()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   n, k;
        rst = 1'b1; stall_ID = 1'b0; flush = 1'b0; fetch_valid = 1'b0;
        fetch_pc = '0; fetch_inst = '0;
        exp_pc = '0; exp_inst = NOP; exp_valid = 1'b0; m_bub = 0; m_stall = 0;

        // Reset held two cycles with a beat offered.
        step(1'b0, 1'b0, 1'b1, 32'h100, acc);
        step(1'b0, 1'b0, 1'b1, 32'h100, acc);
        check("reset_accept", {31'd0, acc}, 32'd0);
        rst = 1'b0;

        // Back-to-back stream through the bypass path.
        step(1'b0, 1'b0, 1'b1, 32'h0, acc);
        step(1'b0, 1'b0, 1'b1, 32'h4, acc);
        step(1'b0, 1'b0, 1'b1, 32'h8, acc);

        // Stall three cycles: 4 and 8 buffered, C held upstream until it is accepted.
        step(1'b1, 1'b0, 1'b1, 32'h4, acc);
        step(1'b1, 1'b0, 1'b1, 32'h8, acc);
        step(1'b1, 1'b0, 1'b1, 32'hC, acc);
        check("stall_full_reject", {31'd0, acc}, 32'd0);
        k = 0;
        do begin
            step(1'b0, 1'b0, 1'b1, 32'hC, acc);
            k++;
        end while (!acc && k < 10);
        check("c_accepted", {31'd0, acc}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0, acc);
        step(1'b0, 1'b0, 1'b0, 32'h0, acc);

        // Flush with a full FIFO, valid output and a same-cycle beat.
        step(1'b0, 1'b0, 1'b1, 32'h40, acc);
        step(1'b1, 1'b0, 1'b1, 32'h44, acc);
        step(1'b1, 1'b0, 1'b1, 32'h48, acc);
        step(1'b1, 1'b1, 1'b1, 32'h10, acc);
        check("flush_nop", inst_ID, NOP);
        step(1'b0, 1'b0, 1'b0, 32'h0, acc);
        step(1'b0, 1'b0, 1'b0, 32'h0, acc);

        // Alternating stall over 12 beats; pointers wrap several times.
        n = 0; k = 0;
        while (n < 12 && k < 200) begin
            step((k % 2) == 0, 1'b0, 1'b1, 32'(n * 4), acc);
            if (acc) n++;
            k++;
        end
        check("wrap_beats", 32'(n), 32'd12);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, acc);

        // Perf scenario: 3 idle advances, 2 stalls, 1 flush.
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'h0, acc);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, acc);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 32'h0, acc);
        step(1'b0, 1'b1, 1'b0, 32'h0, acc);
`ifdef IF_ID_PERF_EN
        check("bubble_cnt", bubble_cnt, 32'(m_bub));
        check("stall_cnt", stall_cnt, 32'(m_stall));
        check("bubble_cnt_abs", bubble_cnt, 32'd3);
        check("stall_cnt_abs", stall_cnt, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
